// File: rtl/iq_demod_pkg.sv
// Shared types, widths and sine-table generator for the iq_demod correlator.
// The table generator is integer-only so it folds to constants at elaboration.
package iq_demod_pkg;

   localparam int PHASE_W    = 32;
   localparam int LUT_AW     = 10;
   localparam int LUT_DW     = 8;
   localparam int SAMP_W     = 8;
   localparam int ACC_W      = 32;
   localparam int PROD_W     = 17;
   localparam int CNT_W      = 16;
   localparam int PIPE_DEPTH = 3;
   localparam int ADC_MID    = 128;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   // round(127*sin(2*pi*addr/1024)): quarter-wave fold plus a Q30 Taylor series
   function automatic logic signed [LUT_DW-1:0] lut_entry(input logic [LUT_AW-1:0] addr);
      longint pi_q30;
      longint x;
      longint term;
      longint sum;
      longint mag;
      logic [8:0] k;
      pi_q30 = 64'sd3373259426;
      k = addr[8] ? (9'd256 - {1'b0, addr[7:0]}) : {1'b0, addr[7:0]};
      x = (pi_q30 * longint'(k)) / 64'sd512;
      term = x;
      sum = x;
      for (int n = 1; n <= 10; n++) begin
         term = -((((term * x) >>> 30) * x) >>> 30) / longint'((2 * n) * (2 * n + 1));
         sum = sum + term;
      end
      mag = (sum * 64'sd127 + 64'sd536870912) >>> 30;
      return addr[9] ? -LUT_DW'(mag) : LUT_DW'(mag);
   endfunction

endpackage

// File: rtl/iq_demod_sincos_lut.sv
// sincos_lut: dual-read-port sine table, one registered read per port per cycle.
module sincos_lut
   import iq_demod_pkg::*;
(
   input  logic                     clk_i,
   input  logic [LUT_AW-1:0]        addr_a_i,
   input  logic [LUT_AW-1:0]        addr_b_i,
   output logic signed [LUT_DW-1:0] data_a_o,
   output logic signed [LUT_DW-1:0] data_b_o
);

   logic signed [LUT_DW-1:0] rom [1 << LUT_AW];

   for (genvar g = 0; g < (1 << LUT_AW); g++) begin : g_rom
      assign rom[g] = lut_entry(LUT_AW'(g));
   end

   always_ff @(posedge clk_i) begin
      data_a_o <= rom[addr_a_i];
      data_b_o <= rom[addr_b_i];
   end

endmodule

// File: rtl/iq_demod.sv
// iq_demod: correlates ADC samples against a DDS-style sin/cos reference over N periods.
// Define IQ_DEMOD_SAT_EN for saturating accumulators; default build wraps modulo 2^32.
module iq_demod
   import iq_demod_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [PHASE_W-1:0]      fword,
   input  logic [CNT_W-1:0]        ncycles,
   input  logic [SAMP_W-1:0]       adc_data,
   input  logic                    adc_valid,
   output logic                    busy,
   output logic                    done,
   output logic signed [ACC_W-1:0] i_acc,
   output logic signed [ACC_W-1:0] q_acc,
   output state_t                  state_o
);

   localparam int SUM_W = ACC_W + 1;

   state_t                   state_q, state_d;
   logic [PHASE_W-1:0]       fword_q, fword_d, phase_q, phase_d;
   logic [CNT_W-1:0]         ncyc_q, ncyc_d, cnt_q, cnt_d, cnt_inc;
   logic [1:0]               flush_q, flush_d;
   logic [PHASE_W:0]         phase_sum;
   logic                     take, wrap, last, clear_acc;

   logic signed [SAMP_W:0]   samp, s1_q;
   logic                     v1_q, v2_q;
   logic [LUT_AW-1:0]        addr_sin, addr_cos;
   logic signed [LUT_DW-1:0] sin_v, cos_v;
   logic signed [PROD_W-1:0] prod_i_q, prod_q_q;
   logic signed [ACC_W-1:0]  i_acc_q, i_acc_d, q_acc_q, q_acc_d;
   logic signed [SUM_W-1:0]  sum_i, sum_q;

   function automatic logic signed [ACC_W-1:0] acc_limit(input logic signed [SUM_W-1:0] s);
`ifdef IQ_DEMOD_SAT_EN
      if (s[SUM_W-1] != s[SUM_W-2])
         return s[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      return s[ACC_W-1:0];
`else
      return s[ACC_W-1:0];
`endif
   endfunction

   // Only RUN consumes samples; the current phase addresses the table before it advances.
   assign take      = (state_q == RUN) && adc_valid;
   assign phase_sum = {1'b0, phase_q} + {1'b0, fword_q};
   assign wrap      = phase_sum[PHASE_W];
   assign cnt_inc   = cnt_q + CNT_W'(1);
   assign last      = take && wrap && (cnt_inc == ncyc_q);
   assign samp      = $signed({1'b0, adc_data} - (SAMP_W + 1)'(ADC_MID));
   assign addr_sin  = phase_q[PHASE_W-1 -: LUT_AW];
   assign addr_cos  = addr_sin + LUT_AW'(1 << (LUT_AW - 2));
   assign sum_i     = SUM_W'(i_acc_q) + SUM_W'(prod_i_q);
   assign sum_q     = SUM_W'(q_acc_q) + SUM_W'(prod_q_q);

   sincos_lut u_lut (
      .clk_i    (clk),
      .addr_a_i (addr_sin),
      .addr_b_i (addr_cos),
      .data_a_o (sin_v),
      .data_b_o (cos_v)
   );

   always_comb begin
      state_d   = state_q;
      fword_d   = fword_q;
      ncyc_d    = ncyc_q;
      phase_d   = phase_q;
      cnt_d     = cnt_q;
      flush_d   = flush_q;
      clear_acc = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = RUN;
               fword_d   = fword;
               ncyc_d    = (ncycles == '0) ? CNT_W'(1) : ncycles;
               phase_d   = '0;
               cnt_d     = '0;
               clear_acc = 1'b1;
            end
         end
         RUN: begin
            if (take) begin
               phase_d = phase_sum[PHASE_W-1:0];
               if (wrap) cnt_d = cnt_inc;
               if (last) begin
                  state_d = FLUSH;
                  flush_d = '0;
               end
            end
         end
         FLUSH: begin
            flush_d = flush_q + 2'd1;
            if (flush_q == 2'(PIPE_DEPTH - 1)) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      i_acc_d = i_acc_q;
      q_acc_d = q_acc_q;
      if (clear_acc) begin
         i_acc_d = '0;
         q_acc_d = '0;
      end else if (v2_q) begin
         i_acc_d = acc_limit(sum_i);
         q_acc_d = acc_limit(sum_q);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         fword_q  <= '0;
         ncyc_q   <= '0;
         phase_q  <= '0;
         cnt_q    <= '0;
         flush_q  <= '0;
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
         s1_q     <= '0;
         prod_i_q <= '0;
         prod_q_q <= '0;
         i_acc_q  <= '0;
         q_acc_q  <= '0;
      end else begin
         state_q  <= state_d;
         fword_q  <= fword_d;
         ncyc_q   <= ncyc_d;
         phase_q  <= phase_d;
         cnt_q    <= cnt_d;
         flush_q  <= flush_d;
         v1_q     <= take;
         s1_q     <= samp;
         v2_q     <= v1_q;
         prod_i_q <= PROD_W'(s1_q) * PROD_W'(cos_v);
         prod_q_q <= PROD_W'(s1_q) * PROD_W'(sin_v);
         i_acc_q  <= i_acc_d;
         q_acc_q  <= q_acc_d;
      end
   end

   assign busy    = (state_q == RUN) || (state_q == FLUSH);
   assign done    = (state_q == DONE);
   assign i_acc   = i_acc_q;
   assign q_acc   = q_acc_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_iq_demod.sv
// Bench for iq_demod: directed vector table, hand sequences and randomized runs vs a real-math model.
module tb_iq_demod;
   import iq_demod_pkg::*;

   logic               clk;
   logic               rst;
   logic               start;
   logic [31:0]        fword;
   logic [15:0]        ncycles;
   logic [7:0]         adc_data;
   logic               adc_valid;
   logic               busy;
   logic               done;
   logic signed [31:0] i_acc;
   logic signed [31:0] q_acc;
   state_t             dbg_state;

   int checks = 0;
   int failures = 0;

   logic [7:0]  samp_q[$];
   logic [63:0] exp_q[$];

   typedef struct {
      logic [31:0] fw;
      logic [15:0] nc;
      int          mode;
      int          gap;
      bit          poke;
      int          exp_n;
   } vec_t;

   vec_t vecs[8];

   iq_demod dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .fword     (fword),
      .ncycles   (ncycles),
      .adc_data  (adc_data),
      .adc_valid (adc_valid),
      .busy      (busy),
      .done      (done),
      .i_acc     (i_acc),
      .q_acc     (q_acc),
      .state_o   (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, $signed(act), $signed(req));
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int lut(input int a);
      real r;
      r = 127.0 * $sin(2.0 * 3.14159265358979323846 * a / 1024.0);
      return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
   endfunction

   function automatic logic signed [63:0] fold(input logic signed [63:0] v);
`ifdef IQ_DEMOD_SAT_EN
      if (v > 64'sd2147483647) return 64'sd2147483647;
      if (v < -64'sd2147483648) return -64'sd2147483648;
      return v;
`else
      return 64'($signed(v[31:0]));
`endif
   endfunction

   // Number of samples consumed until the target count of phase wraps has occurred.
   function automatic int model_n(input logic [31:0] fw, input logic [15:0] nc);
      longint p;
      int carries;
      int tgt;
      p = 0;
      carries = 0;
      tgt = (nc == 16'd0) ? 1 : int'(nc);
      for (int k = 0; k < 100000; k++) begin
         p = p + longint'(fw);
         if (p >= 64'sh1_0000_0000) begin
            p = p - 64'sh1_0000_0000;
            carries++;
         end
         if (carries == tgt) return k + 1;
      end
      return -1;
   endfunction

   task automatic model_acc(input logic [31:0] fw, input int n,
                            output logic signed [31:0] ei, output logic signed [31:0] eq);
      logic [31:0]        p;
      logic signed [63:0] ai;
      logic signed [63:0] aq;
      int                 s;
      p = 32'd0;
      ai = 64'sd0;
      aq = 64'sd0;
      for (int k = 0; k < n; k++) begin
         s  = int'(samp_q[k]) - 128;
         ai = fold(ai + 64'(s * lut((int'(p[31:22]) + 256) % 1024)));
         aq = fold(aq + 64'(s * lut(int'(p[31:22]))));
         p  = p + fw;
      end
      ei = ai[31:0];
      eq = aq[31:0];
   endtask

   function automatic logic [7:0] gen(input int mode, input int k, input logic [31:0] p);
      case (mode)
         0:       return 8'd128;
         1:       return 8'(128 + lut((int'(p[31:22]) + 256) % 1024));
         2:       return 8'(k * 37 + 11);
         3:       return 8'($urandom_range(0, 255));
         default: return 8'd255;
      endcase
   endfunction

   // ---------------- driver + scoreboard for one measurement ----------------
   task automatic run_vec(input vec_t v, input string tag);
      int                 cyc;
      int                 k;
      int                 done_cyc;
      int                 last_c;
      int                 budget;
      logic               busy_late;
      logic [31:0]        p_drv;
      logic signed [31:0] ei;
      logic signed [31:0] eq;
      logic [63:0]        e;
      samp_q.delete();
      exp_q.delete();
      cyc = 0;
      k = 0;
      done_cyc = -1;
      last_c = -1;
      busy_late = 1'b0;
      p_drv = 32'd0;
      budget = v.exp_n * (v.gap + 1) + 20;
      fword = v.fw;
      ncycles = v.nc;
      start = 1'b1;
      step();
      start = 1'b0;
      check({tag, " busy_after_start"}, 32'(busy), 32'd1);
      while (done_cyc < 0 && cyc < budget) begin
         adc_valid = ((cyc % (v.gap + 1)) == v.gap);
         start = v.poke && (cyc == 3);
         fword = start ? ~v.fw : v.fw;
         ncycles = start ? 16'd9 : v.nc;
         if (adc_valid) begin
            adc_data = gen(v.mode, k, p_drv);
            if (k < v.exp_n) begin
               samp_q.push_back(adc_data);
               if (k == v.exp_n - 1) begin
                  last_c = cyc;
                  model_acc(v.fw, v.exp_n, ei, eq);
                  exp_q.push_back({ei, eq});
               end
            end
            k++;
            p_drv = p_drv + v.fw;
         end
         step();
         cyc++;
         if (last_c >= 0 && cyc == last_c + 3) busy_late = busy;
         if (done) done_cyc = cyc;
      end
      adc_valid = 1'b0;
      start = 1'b0;
      fword = v.fw;
      ncycles = v.nc;
      check({tag, " done_cycle"}, 32'(done_cyc), 32'(last_c + 4));
      check({tag, " busy_in_flush"}, 32'(busy_late), 32'd1);
      check({tag, " busy_at_done"}, 32'(busy), 32'd0);
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s result_expected actual=none required=%0d_samples", tag, v.exp_n);
      end else begin
         e = exp_q.pop_front();
         check({tag, " i_acc"}, i_acc, e[63:32]);
         check({tag, " q_acc"}, q_acc, e[31:0]);
         step();
         check({tag, " done_one_cycle"}, 32'(done), 32'd0);
         check({tag, " i_acc_hold"}, i_acc, e[63:32]);
      end
   endtask

   // ---------------- test sequence ----------------
   initial begin : main
      vec_t               r;
      int                 seen;
      logic signed [31:0] ei;
      logic signed [31:0] eq;

      rst = 1'b1;
      start = 1'b0;
      fword = 32'd0;
      ncycles = 16'd0;
      adc_data = 8'd128;
      adc_valid = 1'b0;

      vecs[0] = '{32'h0400_0000, 16'd4,  0, 0, 1'b0, 256};
      vecs[1] = '{32'h0400_0000, 16'd1,  1, 0, 1'b0, 64};
      vecs[2] = '{32'h0400_0000, 16'd1,  1, 0, 1'b1, 64};
      vecs[3] = '{32'h8000_0000, 16'd0,  2, 0, 1'b0, 2};
      vecs[4] = '{32'h8000_0000, 16'd0,  2, 5, 1'b0, 2};
      vecs[5] = '{32'h8000_0000, 16'd3,  2, 1, 1'b0, 6};
      vecs[6] = '{32'hFFFF_FFFF, 16'd2,  2, 0, 1'b0, 3};
      vecs[7] = '{32'h1000_0000, 16'd2,  3, 2, 1'b1, 32};

      repeat (3) step();
      rst = 1'b0;
      check("reset busy", 32'(busy), 32'd0);
      check("reset done", 32'(done), 32'd0);
      check("reset i_acc", i_acc, 32'd0);
      check("reset q_acc", q_acc, 32'd0);

      for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // reset in the middle of RUN aborts without a done pulse
      fword = 32'h0400_0000;
      ncycles = 16'd1;
      start = 1'b1;
      step();
      start = 1'b0;
      adc_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         adc_data = 8'($urandom_range(150, 255));
         step();
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrun_rst busy", 32'(busy), 32'd0);
      check("midrun_rst done", 32'(done), 32'd0);
      check("midrun_rst i_acc", i_acc, 32'd0);
      check("midrun_rst q_acc", q_acc, 32'd0);
      check("midrun_rst state", 32'(dbg_state), 32'(IDLE));
      seen = 0;
      for (int i = 0; i < 70; i++) begin
         step();
         if (done) seen++;
      end
      adc_valid = 1'b0;
      check("midrun_rst no_done", 32'(seen), 32'd0);
      check("midrun_rst i_acc_stays", i_acc, 32'd0);
      run_vec(vecs[1], "after_rst");

      // fword=0 never leaves RUN
      fword = 32'd0;
      ncycles = 16'd1;
      start = 1'b1;
      step();
      start = 1'b0;
      adc_valid = 1'b1;
      seen = 0;
      for (int i = 0; i < 300; i++) begin
         adc_data = 8'($urandom_range(0, 255));
         step();
         if (done) seen++;
      end
      adc_valid = 1'b0;
      check("fword0 busy", 32'(busy), 32'd1);
      check("fword0 no_done", 32'(seen), 32'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;

      // long full-scale run: running sums and the 3-cycle accumulate latency
      samp_q.delete();
      fword = 32'd1;
      ncycles = 16'hFFFF;
      start = 1'b1;
      step();
      start = 1'b0;
      adc_data = 8'd255;
      adc_valid = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         samp_q.push_back(8'd255);
         step();
      end
      adc_valid = 1'b0;
      step();
      model_acc(32'd1, 2999, ei, eq);
      check("fullscale i_acc_before_last", i_acc, ei);
      step();
      model_acc(32'd1, 3000, ei, eq);
      check("fullscale i_acc", i_acc, ei);
      check("fullscale q_acc", q_acc, eq);
      check("fullscale busy", 32'(busy), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;

      // randomized measurements
      for (int i = 0; i < 4; i++) begin
         r.fw = $urandom();
         if (r.fw < 32'h0100_0000) r.fw = r.fw + 32'h0100_0000;
         r.nc = 16'($urandom_range(0, 3));
         r.mode = 3;
         r.gap = $urandom_range(0, 2);
         r.poke = 1'($urandom_range(0, 1));
         r.exp_n = model_n(r.fw, r.nc);
         run_vec(r, $sformatf("rand%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #900000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/iq_demod.md
IQ_DEMOD -- requirements
Module: iq_demod

Interface
REQ-001 SHALL have clk, input, 1, system clock (100 MHz); all logic on rising edge.
REQ-002 SHALL have rst, input, 1, reset, synchronous and active-high.
REQ-003 SHALL have start, input, 1, single-cycle request to begin a measurement.
REQ-004 SHALL have fword, input, 32, reference frequency tuning word; same scaling as the DDS transmitter.
REQ-005 SHALL have ncycles, input, 16, number of reference periods to integrate; 0 is treated as 1.
REQ-006 SHALL have adc_data, input, 8, ADC sample, offset binary (128 = zero).
REQ-007 SHALL have adc_valid, input, 1, qualifies adc_data for one cycle.
REQ-008 SHALL have busy, output, 1, high from the accepted start until done.
REQ-009 SHALL have done, output, 1, one-cycle pulse when i_acc and q_acc are final.
REQ-010 SHALL have i_acc, output, 32 signed, in-phase correlation result; holds until the next accepted start.
REQ-011 SHALL have q_acc, output, 32 signed, quadrature correlation result; holds until the next accepted start.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, FLUSH, DONE.
REQ-013 IDLE: start=1 SHALL latch fword and ncycles, clear the phase accumulator, period counter, i_acc and q_acc, then enter RUN; busy=1 from the next cycle.
REQ-014 start while not in IDLE SHALL be ignored.
REQ-015 RUN, per adc_valid cycle:
- sample s = adc_data - 128, 9-bit signed;
- the sample SHALL use the current phase p; then p <= p + fword (mod 2^32).
REQ-016 Lookup SHALL be sin(p) = LUT(p[31:22]) and cos(p) = LUT(p[31:22] + 256).
- LUT(a) = round(127*sin(2*pi*a/1024)), 8-bit signed.
- Address add wraps modulo 1024.
REQ-017 Datapath pipeline, each stage registered:
- stage 1: lookup;
- stage 2: products s*cos and s*sin, 17-bit signed;
- stage 3: sign-extend and add into i_acc and q_acc.
- Result: 3-cycle latency from an adc_valid sample to its accumulation.
REQ-018 Carry-out of the phase add SHALL increment the period counter.
- When the counter reaches the latched ncycles (min 1), the FSM SHALL enter FLUSH.
- The sample that produced that carry SHALL be included.
- Later adc_valid pulses SHALL be ignored.
REQ-019 FLUSH SHALL last exactly 3 cycles to drain the pipeline, then enter DONE.
REQ-020 DONE SHALL last one cycle with done=1 and busy=0, then enter IDLE.
REQ-021 Cycles without adc_valid SHALL neither advance phase nor inject pipeline data; bubbles propagate.
REQ-022 fword=0 SHALL never end RUN; the only exit from RUN in that case is rst.

Reset
REQ-023 rst=1 SHALL force IDLE and clear the following on the next edge, overriding start, including mid-RUN/FLUSH:
- busy=0, done=0, i_acc=0, q_acc=0;
- phase, period counter and all pipeline valid bits.

Configuration
REQ-024 With IQ_DEMOD_SAT_EN defined, each accumulator SHALL saturate at +2^31-1 / -2^31 and hold there.
REQ-025 Without IQ_DEMOD_SAT_EN, accumulators SHALL wrap modulo 2^32 (two's complement).

Structure
REQ-026 Shared package iq_demod_pkg SHALL hold:
- FSM state typedef;
- constants PHASE_W=32, LUT_AW=10, SAMP_W=8, ACC_W=32, PIPE_DEPTH=3, ADC_MID=128.
REQ-027 The sine table SHALL be one sub-module, sincos_lut.
- Two read ports, 1-cycle registered read, 10-bit address, 8-bit signed data.
- Dual-port allows sin and cos in the same cycle.

Verification
REQ-028 adc_data=128 constantly, adc_valid=1, fword=0x0400_0000, ncycles=4 -> done after 256 samples + 3 flush cycles; i_acc=0, q_acc=0.
REQ-029 adc_data=128+LUT(addr+256) per sample, fword=0x0400_0000, ncycles=1 -> q_acc=0 (exact, symmetric table); i_acc equals the golden-model sum of LUT(addr+256)^2 over the 64 samples.
REQ-030 Pulse start again while busy -> ignored; result and done timing match an uninterrupted run.
REQ-031 rst=1 for one cycle mid-RUN -> next cycle busy=0, i_acc=q_acc=0, no done pulse; a fresh start then completes normally.
REQ-032 ncycles=0, fword=0x8000_0000 -> done after 2 samples (treated as 1 period); adc_valid gaps of 5 cycles between samples -> same result as gap-free.
REQ-033 With IQ_DEMOD_SAT_EN, adc_data=255 constantly, fword=0x0000_0001, ncycles=0xFFFF -> i_acc pins at 0x7FFF_FFFF and does not wrap; without the macro -> value matches the mod-2^32 golden model.
